// File: rtl/burst_ram.sv
// Burst RAM model: word-addressed memory with fixed-length read/write bursts and an init/calibration phase.
// Latency: write beat 0 lands at the accepting edge; first read beat appears READ_LATENCY edges after acceptance.
// Backpressure: busy is high whenever a command would not be accepted; cmd_en while busy is silently dropped.
//
// Ports:
//   clk_ram        RAM clock, rising edge
//   rst            synchronous active-high reset (memory contents are not reset)
//   cmd / cmd_en   command type (0 read, 1 write) and its one-cycle strobe
//   addr           word address of the first beat of a burst
//   wr_data        write beat data, one beat per cycle during a write burst
//   data_mask      per-byte write mask, 1 = keep existing byte
//   rd_data        registered read beat data, holds last beat between bursts
//   rd_data_valid  registered, high for each read beat
//   busy           registered, high while commands are not accepted
//   init_calib     registered, high once initialisation has finished
module burst_ram #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int DATA_BITWIDTH  = 64,
    parameter int BURST_COUNT    = 4,
    parameter int READ_LATENCY   = 3,
    parameter int INIT_CYCLES    = 5
) (
    input  logic                         clk_ram,
    input  logic                         rst,
    input  logic                         cmd,
    input  logic                         cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]    addr,
    input  logic [DATA_BITWIDTH-1:0]     wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]   data_mask,
    output logic [DATA_BITWIDTH-1:0]     rd_data,
    output logic                         rd_data_valid,
    output logic                         busy,
    output logic                         init_calib
);

    localparam int DEPTH     = 1 << DEPTH_BITWIDTH;
    localparam int NUM_BYTES = DATA_BITWIDTH / 8;

    // One shared counter serves init, read latency and beat counting; in
    // READ_BURST it has to reach BURST_COUNT itself, hence the +1 below.
    localparam int CNT_MAX_A = (INIT_CYCLES > READ_LATENCY) ? INIT_CYCLES : READ_LATENCY;
    localparam int CNT_MAX   = (CNT_MAX_A > BURST_COUNT) ? CNT_MAX_A : BURST_COUNT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]          CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]          INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]          LAT_LAST  = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0]          WR_LAST   = CNT_W'(BURST_COUNT - 1);
    localparam logic [CNT_W-1:0]          RD_DONE   = CNT_W'(BURST_COUNT);
    localparam logic [DEPTH_BITWIDTH-1:0] PTR_ONE   = DEPTH_BITWIDTH'(1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ_WAIT,
        ST_READ_BURST,
        ST_WRITE_BURST
    } state_t;

    logic [DATA_BITWIDTH-1:0] mem [DEPTH];

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic [DEPTH_BITWIDTH-1:0] ptr, ptr_nxt;
    logic                      busy_nxt;
    logic                      calib_nxt;
    logic                      valid_nxt;
    logic                      rd_load;
    logic                      mem_we;
    logic [DEPTH_BITWIDTH-1:0] mem_waddr;

    // State and registered outputs
    always_ff @(posedge clk_ram) begin
        if (rst) begin
            state         <= ST_INIT;
            cnt           <= '0;
            ptr           <= '0;
            busy          <= 1'b1;
            init_calib    <= 1'b0;
            rd_data_valid <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            ptr           <= ptr_nxt;
            busy          <= busy_nxt;
            init_calib    <= calib_nxt;
            rd_data_valid <= valid_nxt;
        end
    end

    // Next-state logic. ptr always points at the word for the next beat, so
    // wrap-around falls out of the DEPTH_BITWIDTH-wide increment.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        busy_nxt  = busy;
        calib_nxt = init_calib;
        valid_nxt = 1'b0;
        rd_load   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = ptr;

        case (state)
            ST_INIT: begin
                busy_nxt  = 1'b1;
                calib_nxt = 1'b0;
                if (cnt == INIT_LAST) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    calib_nxt = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            ST_IDLE: begin
                busy_nxt = 1'b0;
                if (cmd_en) begin
                    busy_nxt = 1'b1;
                    if (cmd) begin
                        // Beat 0 is written at the accepting edge itself.
                        mem_we    = 1'b1;
                        mem_waddr = addr;
                        ptr_nxt   = addr + PTR_ONE;
                        cnt_nxt   = CNT_ONE;
                        state_nxt = ST_WRITE_BURST;
                    end else begin
                        ptr_nxt   = addr;
                        cnt_nxt   = '0;
                        state_nxt = ST_READ_WAIT;
                    end
                end
            end

            ST_READ_WAIT: begin
                if (cnt == LAT_LAST) begin
                    rd_load   = 1'b1;
                    valid_nxt = 1'b1;
                    ptr_nxt   = ptr + PTR_ONE;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = ST_READ_BURST;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            ST_READ_BURST: begin
                if (cnt == RD_DONE) begin
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    rd_load   = 1'b1;
                    valid_nxt = 1'b1;
                    ptr_nxt   = ptr + PTR_ONE;
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end

            ST_WRITE_BURST: begin
                mem_we  = 1'b1;
                ptr_nxt = ptr + PTR_ONE;
                if (cnt == WR_LAST) begin
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nxt = ST_INIT;
                busy_nxt  = 1'b1;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Read data register; the nonblocking array read returns the pre-write
    // word when the same address is written at the same edge.
    always_ff @(posedge clk_ram) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_load) begin
            rd_data <= mem[ptr];
        end
    end

    // Storage array: no reset, byte-granular masked writes.
    always_ff @(posedge clk_ram) begin
        if (mem_we && !rst) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (!data_mask[i]) begin
                    mem[mem_waddr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_burst_ram.sv
module tb_burst_ram;

    localparam int AW = 4;
    localparam int DW = 64;
    localparam int B  = 4;
    localparam int L  = 3;
    localparam int IC = 5;

    logic            clk_ram = 1'b0;
    logic            rst;
    logic            cmd;
    logic            cmd_en;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wr_data;
    logic [DW/8-1:0] data_mask;
    logic [DW-1:0]   rd_data;
    logic            rd_data_valid;
    logic            busy;
    logic            init_calib;

    int n_checks = 0;
    int n_fail   = 0;

    typedef logic [DW-1:0] beat4_t [B];
    typedef logic [DW/8-1:0] mask4_t [B];

    burst_ram #(
        .DEPTH_BITWIDTH(AW),
        .DATA_BITWIDTH (DW),
        .BURST_COUNT   (B),
        .READ_LATENCY  (L),
        .INIT_CYCLES   (IC)
    ) dut (
        .clk_ram      (clk_ram),
        .rst          (rst),
        .cmd          (cmd),
        .cmd_en       (cmd_en),
        .addr         (addr),
        .wr_data      (wr_data),
        .data_mask    (data_mask),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .busy         (busy),
        .init_calib   (init_calib)
    );

    always #5 clk_ram = ~clk_ram;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk_ram);
        #1;
    endtask

    // After reset is released, busy/init_calib follow the INIT sequence.
    task automatic check_init(input string tag);
        for (int j = 1; j <= IC; j++) begin
            tick();
            check($sformatf("%s_busy_%0d", tag, j), {63'd0, busy}, (j < IC) ? 64'd1 : 64'd0);
            check($sformatf("%s_calib_%0d", tag, j), {63'd0, init_calib}, (j < IC) ? 64'd0 : 64'd1);
            check($sformatf("%s_valid_%0d", tag, j), {63'd0, rd_data_valid}, 64'd0);
        end
    endtask

    task automatic do_write(input string tag, input logic [AW-1:0] a, input beat4_t d, input mask4_t m);
        cmd = 1'b1; cmd_en = 1'b1; addr = a; wr_data = d[0]; data_mask = m[0];
        tick();
        cmd_en = 1'b0;
        check($sformatf("%s_busy_0", tag), {63'd0, busy}, 64'd1);
        for (int k = 1; k < B; k++) begin
            wr_data = d[k]; data_mask = m[k];
            tick();
            check($sformatf("%s_busy_%0d", tag, k), {63'd0, busy}, (k < B-1) ? 64'd1 : 64'd0);
            check($sformatf("%s_valid_%0d", tag, k), {63'd0, rd_data_valid}, 64'd0);
        end
        wr_data = '0; data_mask = '1;
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a, input beat4_t e);
        cmd = 1'b0; cmd_en = 1'b1; addr = a;
        tick();
        cmd_en = 1'b0;
        for (int j = 1; j <= L + B; j++) begin
            tick();
            check($sformatf("%s_valid_%0d", tag, j), {63'd0, rd_data_valid},
                  (j >= L && j < L + B) ? 64'd1 : 64'd0);
            check($sformatf("%s_busy_%0d", tag, j), {63'd0, busy}, (j < L + B) ? 64'd1 : 64'd0);
            if (j >= L && j < L + B)
                check($sformatf("%s_beat_%0d", tag, j - L), rd_data, e[j-L]);
        end
        check($sformatf("%s_hold", tag), rd_data, e[B-1]);
    endtask

    beat4_t d_inc, d_ones, d_zero, d_wrap, e_wrap0;
    mask4_t m_none, m_beat0;

    initial begin
        rst = 1'b1; cmd = 1'b0; cmd_en = 1'b0; addr = '0; wr_data = '0; data_mask = '1;
        d_inc   = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
        d_ones  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        d_zero  = '{64'd0, 64'd0, 64'd0, 64'd0};
        d_wrap  = '{64'hA0A0A0A0A0A0A0A0, 64'hB1B1B1B1B1B1B1B1, 64'hC2C2C2C2C2C2C2C2, 64'hD3D3D3D3D3D3D3D3};
        e_wrap0 = '{64'hC2C2C2C2C2C2C2C2, 64'hD3D3D3D3D3D3D3D3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        m_none  = '{8'h00, 8'h00, 8'h00, 8'h00};
        m_beat0 = '{8'h0F, 8'hFF, 8'hFF, 8'hFF};

        // Reset state
        tick(); tick(); tick();
        check("rst_busy",  {63'd0, busy}, 64'd1);
        check("rst_calib", {63'd0, init_calib}, 64'd0);
        check("rst_valid", {63'd0, rd_data_valid}, 64'd0);
        check("rst_rdata", rd_data, 64'd0);

        // INIT with a read strobe pulsed during it: must be ignored
        rst = 1'b0;
        cmd = 1'b0; cmd_en = 1'b1; addr = 4'd2;
        for (int j = 1; j <= IC; j++) begin
            if (j == IC) cmd_en = 1'b0;
            tick();
            check($sformatf("init_busy_%0d", j), {63'd0, busy}, (j < IC) ? 64'd1 : 64'd0);
            check($sformatf("init_calib_%0d", j), {63'd0, init_calib}, (j < IC) ? 64'd0 : 64'd1);
        end
        for (int j = 0; j < L + B + 2; j++) begin
            tick();
            check("init_ignored_valid", {63'd0, rd_data_valid}, 64'd0);
            check("init_ignored_busy",  {63'd0, busy}, 64'd0);
        end

        // Basic write/read burst
        do_write("wr4", 4'd4, d_inc, m_none);
        tick();
        do_read("rd4", 4'd4, d_inc);

        // Byte mask
        tick();
        do_write("wr_ones", 4'd0, d_ones, m_none);
        tick();
        do_write("wr_mask", 4'd0, d_zero, m_beat0);
        tick();
        do_read("rd_mask", 4'd0,
                '{64'h00000000FFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF});

        // Address wrap
        tick();
        do_write("wr_wrap", 4'd14, d_wrap, m_none);
        tick();
        do_read("rd_wrap0", 4'd0, e_wrap0);
        tick();
        do_read("rd_wrap14", 4'd14, d_wrap);

        // Reset in the middle of a read burst
        tick();
        cmd = 1'b0; cmd_en = 1'b1; addr = 4'd4;
        tick();
        cmd_en = 1'b0;
        for (int j = 1; j <= L + 1; j++) tick();
        check("abort_beat1_valid", {63'd0, rd_data_valid}, 64'd1);
        check("abort_beat1_data",  rd_data, 64'h2222222222222222);
        rst = 1'b1;
        tick();
        check("abort_valid", {63'd0, rd_data_valid}, 64'd0);
        check("abort_calib", {63'd0, init_calib}, 64'd0);
        check("abort_busy",  {63'd0, busy}, 64'd1);
        check("abort_rdata", rd_data, 64'd0);
        rst = 1'b0;
        check_init("reinit");
        tick();
        do_read("rd_after_rst", 4'd4, d_inc);

        // cmd_en held high across two back-to-back reads
        tick();
        cmd = 1'b0; cmd_en = 1'b1; addr = 4'd14;
        tick();
        for (int j = 1; j <= 2 * (L + B) + 1; j++) begin
            int s2;
            s2 = 2 * L + B + 1;
            tick();
            if (j == L + B + 1) cmd_en = 1'b0;
            check($sformatf("b2b_valid_%0d", j), {63'd0, rd_data_valid},
                  ((j >= L && j < L + B) || (j >= s2 && j < s2 + B)) ? 64'd1 : 64'd0);
            if (j >= L && j < L + B)
                check($sformatf("b2b_a_beat_%0d", j - L), rd_data, d_wrap[j-L]);
            if (j >= s2 && j < s2 + B)
                check($sformatf("b2b_b_beat_%0d", j - s2), rd_data, d_wrap[j-s2]);
            if (j == L + B)
                check("b2b_busy_gap", {63'd0, busy}, 64'd0);
            if (j == L + B + 1)
                check("b2b_busy_second", {63'd0, busy}, 64'd1);
        end
        check("b2b_end_busy", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
